shiftsub_divider: RTL

//  Sequential restoring (shift-subtract) unsigned divider; the inverse of our shift-add multiplier.

---
 rtl/shiftsub_pkg.sv | 18 +
 rtl/datapath_shiftsub_divider.sv | 87 ++++++++
 rtl/shiftsub_divider.sv | 110 +++++++++++
 3 files changed

// File: rtl/shiftsub_pkg.sv
// Shared definitions for the shift-subtract divider: FSM state encodings and
// the iteration-counter width helper.
package shiftsub_pkg;

   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_CALC = 2'd1;
   localparam logic [STATE_W-1:0] ST_FIN  = 2'd2;

   // Counter width: $clog2(width) bits, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      int unsigned c;
      c = $clog2(width);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/datapath_shiftsub_divider.sv
// Datapath of the restoring divider: working registers R (partial remainder,
// WIDTH+1 bits), Q (dividend shifting into quotient), D (divisor), the trial
// subtractor and the held result registers.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              capture operands, clear R
//   step              perform one shift-subtract iteration
//   latch_out         update quotient/remainder/div_by_zero
//   dbz               with latch_out: write the divide-by-zero result
//   dividend, divisor operands
//   quotient, remainder, div_by_zero  registered results
module datapath_shiftsub_divider #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             latch_out,
   input  logic             dbz,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   logic [WIDTH:0]   r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;

   logic [WIDTH:0]   s;
   logic [WIDTH:0]   t;
   logic [WIDTH:0]   r_nxt;
   logic [WIDTH-1:0] q_nxt;

   // The top bit of R only ever carries the subtract borrow path; after each
   // step it is zero because the remainder stays below the divisor.
   logic unused_r_msb;
   assign unused_r_msb = r_q[WIDTH];

   // Trial subtraction; a set borrow bit means restore the shifted value.
   always_comb begin
      s     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      t     = s - {1'b0, d_q};
      r_nxt = t[WIDTH] ? s : t;
      q_nxt = {q_q[WIDTH-2:0], ~t[WIDTH]};
   end

   // Working registers and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (load) begin
            r_q <= '0;
            q_q <= dividend;
            d_q <= divisor;
         end else if (step) begin
            r_q <= r_nxt;
            q_q <= q_nxt;
         end

         // Results latch together with the final step so they are valid in
         // the done cycle; a divide by zero latches at acceptance instead.
         if (latch_out) begin
            if (dbz) begin
               quotient    <= '1;
               remainder   <= dividend;
               div_by_zero <= 1'b1;
            end else begin
               quotient    <= q_nxt;
               remainder   <= r_nxt[WIDTH-1:0];
               div_by_zero <= 1'b0;
            end
         end else if (load) begin
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/shiftsub_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock, with a
// start/done handshake. Holds the control FSM and iteration counter.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request a division (sampled in IDLE only)
//   dividend, divisor   operands, captured on acceptance
//   busy                high while iterating
//   done                one-cycle completion pulse
//   div_by_zero         result flag for a zero divisor
//   quotient, remainder held results
module shiftsub_divider
   import shiftsub_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;

   logic load;
   logic step;
   logic latch_out;
   logic dbz_sel;

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      load      = 1'b0;
      step      = 1'b0;
      latch_out = 1'b0;
      dbz_sel   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               count_d = '0;
               if (divisor == '0) begin
                  latch_out = 1'b1;
                  dbz_sel   = 1'b1;
                  state_d   = ST_FIN;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            step    = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH - 1)) begin
               latch_out = 1'b1;
               state_d   = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status flags decode directly from the state register.
   assign busy = (state_q == ST_CALC);
   assign done = (state_q == ST_FIN);

   datapath_shiftsub_divider #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .step        (step),
      .latch_out   (latch_out),
      .dbz         (dbz_sel),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

endmodule
